// File: rtl/legv8_pkg.sv
// LEGv8 ID/EX shared definitions: ALU control codes, opcode patterns,
// instruction field positions and the decoded control bundle.
package legv8_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_LSL   = 4'b0011;
    localparam logic [3:0] ALU_LSR   = 4'b0100;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_ADDI = 11'b10010001000;
    localparam logic [10:0] OP_SUBI = 11'b11010001000;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_MOVZ = 11'b11010010100;
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;
    localparam logic [10:0] OP_B    = 11'b00010100000;

    localparam logic [10:0] MASK_FULL = 11'b11111111111;
    localparam logic [10:0] MASK_IMM  = 11'b11111111110;
    localparam logic [10:0] MASK_IW   = 11'b11111111100;
    localparam logic [10:0] MASK_CB   = 11'b11111111000;
    localparam logic [10:0] MASK_B    = 11'b11111100000;

    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 21;
    localparam int RD_HI    = 4;
    localparam int RD_LO    = 0;
    localparam int ALUI_HI  = 21;
    localparam int ALUI_LO  = 10;
    localparam int SHAMT_HI = 15;
    localparam int SHAMT_LO = 10;
    localparam int DADDR_HI = 20;
    localparam int DADDR_LO = 12;
    localparam int MOV_HI   = 20;
    localparam int MOV_LO   = 5;
    localparam int HW_HI    = 22;
    localparam int HW_LO    = 21;
    localparam int CB_HI    = 23;
    localparam int CB_LO    = 5;
    localparam int BR_HI    = 25;
    localparam int BR_LO    = 0;

    // Strobe sets: {reg_write, mem_read, mem_write, mem_to_reg, branch, uncond}
    localparam logic [5:0] CF_WB = 6'b100000;
    localparam logic [5:0] CF_LD = 6'b110100;
    localparam logic [5:0] CF_ST = 6'b001000;
    localparam logic [5:0] CF_CB = 6'b000010;
    localparam logic [5:0] CF_B  = 6'b000001;

    typedef enum logic [2:0] {
        FMT_ILL, FMT_R, FMT_I, FMT_SH, FMT_D, FMT_IW, FMT_CB, FMT_B
    } fmt_e;

    typedef struct packed {
        logic [3:0] alu_ctrl;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       uncond;
    } ctrl_t;

    function automatic logic op_is(input logic [10:0] opc,
                                   input logic [10:0] pat,
                                   input logic [10:0] mask);
        return (opc & mask) == pat;
    endfunction

endpackage

// File: rtl/legv8_imm_gen.sv
// Immediate and branch-offset generator for the LEGv8 ID stage.
// Purely combinational; fields not used by a format produce zero.
module legv8_imm_gen #(
    parameter int n = 63
) (
    input  logic [31:0] instr,
    input  logic [2:0]  fmt,
    output logic [n:0]  imm,
    output logic [n:0]  br_off
);
    import legv8_pkg::*;

    logic [n:0] mov_base;
    logic [5:0] mov_sh;
    logic       unused_hi;

    assign unused_hi = ^instr[31:26];
    assign mov_base  = {{(n-15){1'b0}}, instr[MOV_HI:MOV_LO]};
    assign mov_sh    = {instr[HW_HI:HW_LO], 4'b0000};

    always_comb begin
        imm    = '0;
        br_off = '0;
        unique case (fmt)
            FMT_I:  imm = {{(n-11){1'b0}}, instr[ALUI_HI:ALUI_LO]};
            FMT_SH: imm = {{(n-5){1'b0}}, instr[SHAMT_HI:SHAMT_LO]};
            FMT_D:  imm = {{(n-8){instr[DADDR_HI]}},
                           instr[DADDR_HI:DADDR_LO]};
            FMT_IW: imm = mov_base << mov_sh;
            // Branch offsets are word offsets, so scale by 4 here
            FMT_CB: br_off = {{(n-20){instr[CB_HI]}},
                              instr[CB_HI:CB_LO], 2'b00};
            FMT_B:  br_off = {{(n-27){instr[BR_HI]}},
                              instr[BR_HI:BR_LO], 2'b00};
            default: ;
        endcase
    end

endmodule

// File: rtl/legv8_alu_issue_stage.sv
// LEGv8 ID/EX register: decodes the ID instruction and drives the ALU
// operands, control code and mem/wb/branch strobes one cycle later.
module legv8_alu_issue_stage #(
    parameter int n = 63
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        InValid,
    input  logic [31:0] Instruction,
    input  logic [n:0]  RegA,
    input  logic [n:0]  RegB,
    input  logic [n:0]  PC,
    output logic [n:0]  BusA,
    output logic [n:0]  BusB,
    output logic [3:0]  ALUCtrl,
    output logic [n:0]  StoreData,
    output logic [n:0]  BranchTarget,
    output logic [4:0]  Rd,
    output logic        OutValid,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemToReg,
    output logic        Branch,
    output logic        UncondBranch,
    output logic        IllegalOp
);
    import legv8_pkg::*;

    fmt_e       fmt;
    ctrl_t      dec_ctrl;
    logic [10:0] opc;
    logic [n:0] imm, br_off;
    logic [n:0] ld_bus_a, ld_bus_b, ld_store, ld_target;
    logic       illegal;

    ctrl_t      ctrl_d, ctrl_q;
    logic [n:0] bus_a_d, bus_a_q;
    logic [n:0] bus_b_d, bus_b_q;
    logic [n:0] store_d, store_q;
    logic [n:0] target_d, target_q;
    logic [4:0] rd_d, rd_q;
    logic       valid_d, valid_q;
    logic       illegal_d, illegal_q;

    assign opc     = Instruction[OPC_HI:OPC_LO];
    assign illegal = (fmt == FMT_ILL);

    always_comb begin
        fmt      = FMT_ILL;
        dec_ctrl = '0;
        unique case (1'b1)
            op_is(opc, OP_ADD, MASK_FULL):  begin fmt = FMT_R;  dec_ctrl = {ALU_ADD, CF_WB}; end
            op_is(opc, OP_SUB, MASK_FULL):  begin fmt = FMT_R;  dec_ctrl = {ALU_SUB, CF_WB}; end
            op_is(opc, OP_AND, MASK_FULL):  begin fmt = FMT_R;  dec_ctrl = {ALU_AND, CF_WB}; end
            op_is(opc, OP_ORR, MASK_FULL):  begin fmt = FMT_R;  dec_ctrl = {ALU_OR, CF_WB}; end
            op_is(opc, OP_ADDI, MASK_IMM):  begin fmt = FMT_I;  dec_ctrl = {ALU_ADD, CF_WB}; end
            op_is(opc, OP_SUBI, MASK_IMM):  begin fmt = FMT_I;  dec_ctrl = {ALU_SUB, CF_WB}; end
            op_is(opc, OP_LSL, MASK_FULL):  begin fmt = FMT_SH; dec_ctrl = {ALU_LSL, CF_WB}; end
            op_is(opc, OP_LSR, MASK_FULL):  begin fmt = FMT_SH; dec_ctrl = {ALU_LSR, CF_WB}; end
            op_is(opc, OP_LDUR, MASK_FULL): begin fmt = FMT_D;  dec_ctrl = {ALU_ADD, CF_LD}; end
            op_is(opc, OP_STUR, MASK_FULL): begin fmt = FMT_D;  dec_ctrl = {ALU_ADD, CF_ST}; end
            op_is(opc, OP_MOVZ, MASK_IW):   begin fmt = FMT_IW; dec_ctrl = {ALU_PASSB, CF_WB}; end
            op_is(opc, OP_CBZ, MASK_CB):    begin fmt = FMT_CB; dec_ctrl = {ALU_PASSB, CF_CB}; end
            op_is(opc, OP_B, MASK_B):       begin fmt = FMT_B;  dec_ctrl = {ALU_PASSB, CF_B}; end
            default: ;
        endcase
    end

    legv8_imm_gen #(.n(n)) u_imm_gen (
        .instr  (Instruction),
        .fmt    (fmt),
        .imm    (imm),
        .br_off (br_off)
    );

    // BusB defaults to the immediate, which is zero for B and illegal ops
    always_comb begin
        ld_bus_a  = '0;
        ld_bus_b  = imm;
        ld_store  = '0;
        ld_target = '0;
        unique case (fmt)
            FMT_R: begin
                ld_bus_a = RegA;
                ld_bus_b = RegB;
            end
            FMT_I, FMT_SH, FMT_D: ld_bus_a = RegA;
            FMT_CB: begin
                ld_bus_b  = RegB;
                ld_target = PC + br_off;
            end
            FMT_B:  ld_target = PC + br_off;
            default: ;
        endcase
        if (dec_ctrl.mem_write)
            ld_store = RegB;
    end

    always_comb begin
        ctrl_d    = ctrl_q;
        bus_a_d   = bus_a_q;
        bus_b_d   = bus_b_q;
        store_d   = store_q;
        target_d  = target_q;
        rd_d      = rd_q;
        valid_d   = valid_q;
        illegal_d = illegal_q;
        if (Flush || !Stall) begin
            if (Flush || !InValid || illegal) begin
                ctrl_d    = '0;
                bus_a_d   = '0;
                bus_b_d   = '0;
                store_d   = '0;
                target_d  = '0;
                rd_d      = '0;
                valid_d   = 1'b0;
                illegal_d = !Flush && InValid && illegal;
            end else begin
                ctrl_d    = dec_ctrl;
                bus_a_d   = ld_bus_a;
                bus_b_d   = ld_bus_b;
                store_d   = ld_store;
                target_d  = ld_target;
                rd_d      = Instruction[RD_HI:RD_LO];
                valid_d   = 1'b1;
                illegal_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            ctrl_q    <= '0;
            bus_a_q   <= '0;
            bus_b_q   <= '0;
            store_q   <= '0;
            target_q  <= '0;
            rd_q      <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            bus_a_q   <= bus_a_d;
            bus_b_q   <= bus_b_d;
            store_q   <= store_d;
            target_q  <= target_d;
            rd_q      <= rd_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
        end
    end

    assign BusA         = bus_a_q;
    assign BusB         = bus_b_q;
    assign ALUCtrl      = ctrl_q.alu_ctrl;
    assign StoreData    = store_q;
    assign BranchTarget = target_q;
    assign Rd           = rd_q;
    assign OutValid     = valid_q;
    assign RegWrite     = ctrl_q.reg_write;
    assign MemRead      = ctrl_q.mem_read;
    assign MemWrite     = ctrl_q.mem_write;
    assign MemToReg     = ctrl_q.mem_to_reg;
    assign Branch       = ctrl_q.branch;
    assign UncondBranch = ctrl_q.uncond;
    assign IllegalOp    = illegal_q;

endmodule

// File: tb/tb_legv8_alu_issue_stage.sv
// Randomized bench for legv8_alu_issue_stage against an opcode-table
// reference model with Reset > Flush > Stall > load sequencing.
`timescale 1ns/1ps
module tb_legv8_alu_issue_stage;

    logic        CLK = 1'b0;
    logic        Reset, Stall, Flush, InValid;
    logic [31:0] Instruction;
    logic [63:0] RegA, RegB, PC;
    logic [63:0] BusA, BusB, StoreData, BranchTarget;
    logic [3:0]  ALUCtrl;
    logic [4:0]  Rd;
    logic        OutValid, RegWrite, MemRead, MemWrite;
    logic        MemToReg, Branch, UncondBranch, IllegalOp;

    legv8_alu_issue_stage #(.n(63)) dut (
        .CLK(CLK), .Reset(Reset), .Stall(Stall), .Flush(Flush),
        .InValid(InValid), .Instruction(Instruction),
        .RegA(RegA), .RegB(RegB), .PC(PC),
        .BusA(BusA), .BusB(BusB), .ALUCtrl(ALUCtrl),
        .StoreData(StoreData), .BranchTarget(BranchTarget), .Rd(Rd),
        .OutValid(OutValid), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemToReg(MemToReg), .Branch(Branch),
        .UncondBranch(UncondBranch), .IllegalOp(IllegalOp)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [63:0] a, b, st, tgt;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic [7:0]  fl;
    } exp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q   = '0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [63:0] sx(input longint v, input int bits);
        longint m;
        m = longint'(1) << bits;
        v = v & (m - 1);
        if (v >= m / 2) v = v - m;
        return v;
    endfunction

    // Flags: {OutValid, RegWrite, MemRead, MemWrite, MemToReg, Branch, Uncond, Illegal}
    function automatic exp_t model(input logic [31:0] ins, input logic [63:0] ra,
                                   input logic [63:0] rb, input logic [63:0] pc,
                                   input logic inv);
        exp_t e;
        logic ok;
        logic [5:0] f;
        e = '0;
        ok = 1'b1;
        f = 6'b0;
        casez (ins[31:21])
            11'b10001011000: begin e.a = ra; e.b = rb; e.alu = 2; f = 6'b100000; end
            11'b11001011000: begin e.a = ra; e.b = rb; e.alu = 6; f = 6'b100000; end
            11'b10001010000: begin e.a = ra; e.b = rb; e.alu = 0; f = 6'b100000; end
            11'b10101010000: begin e.a = ra; e.b = rb; e.alu = 1; f = 6'b100000; end
            11'b1001000100?: begin e.a = ra; e.b = 64'(ins[21:10]); e.alu = 2; f = 6'b100000; end
            11'b1101000100?: begin e.a = ra; e.b = 64'(ins[21:10]); e.alu = 6; f = 6'b100000; end
            11'b11010011011: begin e.a = ra; e.b = 64'(ins[15:10]); e.alu = 3; f = 6'b100000; end
            11'b11010011010: begin e.a = ra; e.b = 64'(ins[15:10]); e.alu = 4; f = 6'b100000; end
            11'b11111000010: begin e.a = ra; e.b = sx(longint'(ins[20:12]), 9); e.alu = 2; f = 6'b110100; end
            11'b11111000000: begin
                e.a = ra; e.b = sx(longint'(ins[20:12]), 9); e.alu = 2;
                e.st = rb; f = 6'b001000;
            end
            11'b110100101??: begin e.b = 64'(ins[20:5]) << (16 * ins[22:21]); e.alu = 7; f = 6'b100000; end
            11'b10110100???: begin
                e.b = rb; e.alu = 7; f = 6'b000010;
                e.tgt = pc + sx(longint'(ins[23:5]), 19) * 4;
            end
            11'b000101?????: begin
                e.alu = 7; f = 6'b000001;
                e.tgt = pc + sx(longint'(ins[25:0]), 26) * 4;
            end
            default: ok = 1'b0;
        endcase
        if (inv && ok) begin
            e.rd = ins[4:0];
            e.fl = {1'b1, f, 1'b0};
        end else begin
            e = '0;
            e.fl = {7'b0, inv};
        end
        return e;
    endfunction

    task automatic cycle(input logic rst, input logic stl, input logic fl,
                         input logic inv, input logic [31:0] ins,
                         input logic [63:0] ra, input logic [63:0] rb,
                         input logic [63:0] pc);
        Reset = rst; Stall = stl; Flush = fl; InValid = inv;
        Instruction = ins; RegA = ra; RegB = rb; PC = pc;
        if (rst || fl) exp_q = '0;
        else if (!stl) exp_q = model(ins, ra, rb, pc, inv);
        @(posedge CLK);
        #1;
        check("BusA", BusA, exp_q.a);
        check("BusB", BusB, exp_q.b);
        check("ALUCtrl", 64'(ALUCtrl), 64'(exp_q.alu));
        check("StoreData", StoreData, exp_q.st);
        check("BranchTarget", BranchTarget, exp_q.tgt);
        check("Rd", 64'(Rd), 64'(exp_q.rd));
        check("flags", 64'({OutValid, RegWrite, MemRead, MemWrite, MemToReg,
                            Branch, UncondBranch, IllegalOp}), 64'(exp_q.fl));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 13))
            0:  r[31:21] = 11'b10001011000;
            1:  r[31:21] = 11'b11001011000;
            2:  r[31:21] = 11'b10001010000;
            3:  r[31:21] = 11'b10101010000;
            4:  r[31:22] = 10'b1001000100;
            5:  r[31:22] = 10'b1101000100;
            6:  r[31:21] = 11'b11010011011;
            7:  r[31:21] = 11'b11010011010;
            8:  r[31:21] = 11'b11111000010;
            9:  r[31:21] = 11'b11111000000;
            10: r[31:23] = 9'b110100101;
            11: r[31:24] = 8'b10110100;
            12: r[31:26] = 6'b000101;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        cycle(1, 0, 0, 0, 32'h0, 64'h0, 64'h0, 64'h0);
        check("reset_valid", 64'(OutValid), 64'd0);

        cycle(0, 0, 0, 1, 32'h8B020023, 64'd5, 64'd7, 64'h0);
        check("add_busa", BusA, 64'd5);
        check("add_busb", BusB, 64'd7);
        check("add_alu", 64'(ALUCtrl), 64'h2);
        check("add_rd", 64'(Rd), 64'd3);
        check("add_wr_valid", 64'({RegWrite, OutValid}), 64'h3);

        cycle(0, 0, 0, 1, 32'h91001441, 64'd9, 64'd1, 64'h0);
        check("addi_busb", BusB, 64'd5);
        check("addi_rd", 64'(Rd), 64'd1);

        cycle(0, 0, 0, 1, 32'hF85F8025, 64'd100, 64'd3, 64'h0);
        check("ldur_busb", BusB, 64'hFFFF_FFFF_FFFF_FFF8);
        check("ldur_strobes", 64'({MemRead, MemToReg, RegWrite}), 64'h7);

        cycle(0, 0, 0, 1, 32'hB4FFFFC9, 64'd4, 64'd0, 64'h100);
        check("cbz_target", BranchTarget, 64'hF8);
        check("cbz_branch", 64'(Branch), 64'd1);
        check("cbz_alu", 64'(ALUCtrl), 64'h7);

        cycle(0, 0, 0, 1, 32'h8B020023, 64'd5, 64'd7, 64'h0);
        for (int i = 0; i < 3; i++)
            cycle(0, 1, 0, 1, rand_instr(), {$urandom, $urandom},
                  {$urandom, $urandom}, {$urandom, $urandom});
        check("stall_busa", BusA, 64'd5);
        cycle(0, 1, 1, 1, 32'h8B020023, 64'd5, 64'd7, 64'h0);
        check("flush_valid", 64'(OutValid), 64'd0);

        cycle(0, 0, 0, 1, 32'hFFFFFFFF, 64'd1, 64'd2, 64'h0);
        check("illegal_set", 64'(IllegalOp), 64'd1);
        cycle(0, 0, 0, 0, 32'h8B020023, 64'd1, 64'd2, 64'h0);
        check("invalid_bubble", 64'(IllegalOp), 64'd0);

        cycle(0, 0, 0, 1, 32'h8B020023, 64'd5, 64'd7, 64'h0);
        cycle(1, 1, 0, 1, 32'h8B020023, 64'd5, 64'd7, 64'h0);
        check("reset_stall_busa", BusA, 64'd0);

        cycle(0, 0, 0, 1, 32'h17FFFFFF, 64'd0, 64'd0, 64'h0);
        check("b_wrap", BranchTarget, 64'hFFFF_FFFF_FFFF_FFFC);

        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 99) < 3,
                  $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 90,
                  rand_instr(),
                  {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
